// File: rtl/verin_adc_pkg.sv
// Shared constants for the actuator position ADC slave:
// register map, bit positions, SPI frame shape and FSM states.
package verin_adc_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_THRESH = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_CONT  = 0;
   localparam int CTRL_START = 1;

   localparam int DATA_NEW     = 31;
   localparam int THR_HIGH_LSB = 16;

   localparam int ST_BUSY    = 0;
   localparam int ST_ABOVE   = 1;
   localparam int ST_BELOW   = 2;
   localparam int ST_CNT_LSB = 16;

   // MCP3201 frame: 2 sample clocks + null bit, then B11..B0
   localparam int FRAME_BITS = 15;
   localparam int FRAME_SKIP = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD
   } spi_state_e;

endpackage

// File: rtl/verin_adc_avalon_if.sv
// Avalon-MM slave bundle for the actuator ADC register block.
interface verin_adc_avalon_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/verin_adc_spi_rx.sv
// MCP3201-style SPI receiver: SCLK divider, bit counter, shift register.
module verin_adc_spi_rx
   import verin_adc_pkg::*;
#(
   parameter int CLK_DIV = 25,
   parameter int DATA_W  = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data,
   output logic              adc_cs_n,
   output logic              adc_sclk,
   input  logic              adc_dout
);

   localparam logic [7:0] DIV_END  = 8'(CLK_DIV - 1);
   localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
   localparam logic [3:0] BIT_KEEP = 4'(FRAME_SKIP);

   spi_state_e        state_q, state_d;
   logic [7:0]        div_cnt;
   logic [3:0]        bit_cnt;
   logic              sclk_q;
   logic              cs_n_q;
   logic [DATA_W-1:0] sh;
   logic              tick;

   assign tick = (div_cnt == DIV_END);

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: if (tick) state_d = S_SHIFT;
         S_SHIFT: begin
            if (tick && sclk_q && bit_cnt == BIT_LAST) begin
               state_d = S_HOLD;
               done    = 1'b1;
            end
         end
         S_HOLD:  if (tick) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         sh      <= '0;
      end else begin
         state_q <= state_d;
         cs_n_q  <= !(state_d == S_SETUP || state_d == S_SHIFT);
         if (state_q == S_IDLE || tick) div_cnt <= '0;
         else div_cnt <= div_cnt + 8'd1;
         if (state_q != S_SHIFT) bit_cnt <= '0;
         // rising edge samples dout; falling edge closes the bit
         if (state_q == S_SHIFT && tick) begin
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
               if (bit_cnt >= BIT_KEEP) sh <= {sh[DATA_W-2:0], adc_dout};
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign data     = sh;
   assign adc_cs_n = cs_n_q;
   assign adc_sclk = sclk_q;

endmodule

// File: rtl/verin_adc_avalon.sv
// Avalon-MM slave sampling the actuator position pot through a SPI ADC,
// with window compare driving out_of_range for the LED PIO firmware.
module verin_adc_avalon
   import verin_adc_pkg::*;
#(
   parameter int CLK_DIV = 25,
   parameter int PERIOD  = 50000,
   parameter int DATA_W  = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   verin_adc_avalon_if.slave    av,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   input  logic                 adc_dout,
   output logic                 out_of_range
);

   localparam int TW = $clog2(PERIOD + 1);
   localparam logic [TW-1:0] TMR_END = TW'(PERIOD - 1);

   logic              wr, rd, wr_ctrl, wr_thr, rd_data;
   logic              start, expire, busy, done;
   logic [DATA_W-1:0] data;
   logic              cont;
   logic [DATA_W-1:0] low, high, sample;
   logic              new_f;
   logic [15:0]       smp_cnt;
   logic [TW-1:0]     tmr;
   logic              cmp_pend, above, below, oor;
   logic [31:0]       rdata;
   logic              unused_wd;

   assign wr      = av.chipselect & ~av.write_n;
   assign rd      = av.chipselect & ~av.read_n;
   assign wr_ctrl = wr && av.address == ADDR_CTRL;
   assign wr_thr  = wr && av.address == ADDR_THRESH;
   assign rd_data = rd && av.address == ADDR_DATA;

   assign expire = cont && tmr == TMR_END;
   assign start  = ~busy & ((wr_ctrl & av.writedata[CTRL_START]) | expire);

   assign unused_wd = &{1'b0, av.writedata};

   verin_adc_spi_rx #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (DATA_W)
   ) u_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .data     (data),
      .adc_cs_n (adc_cs_n),
      .adc_sclk (adc_sclk),
      .adc_dout (adc_dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cont     <= 1'b0;
         low      <= '0;
         high     <= '1;
         sample   <= '0;
         new_f    <= 1'b0;
         smp_cnt  <= '0;
         tmr      <= '0;
         cmp_pend <= 1'b0;
         above    <= 1'b0;
         below    <= 1'b0;
         oor      <= 1'b0;
      end else begin
         if (wr_ctrl) cont <= av.writedata[CTRL_CONT];
         if (wr_thr) begin
            low  <= av.writedata[DATA_W-1:0];
            high <= av.writedata[THR_HIGH_LSB +: DATA_W];
         end
         if (start) tmr <= '0;
         else if (tmr != TMR_END) tmr <= tmr + 1'b1;
         // a fresh sample beats a coincident DATA read
         if (done) begin
            sample  <= data;
            new_f   <= 1'b1;
            smp_cnt <= smp_cnt + 16'd1;
         end else if (rd_data) begin
            new_f <= 1'b0;
         end
         cmp_pend <= done;
         if (cmp_pend) begin
            above <= sample > high;
            below <= sample < low;
            oor   <= (sample > high) | (sample < low);
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (av.address)
         ADDR_DATA: begin
            rdata[DATA_W-1:0] = sample;
            rdata[DATA_NEW]   = new_f;
         end
         ADDR_CTRL: rdata[CTRL_CONT] = cont;
         ADDR_THRESH: begin
            rdata[DATA_W-1:0]            = low;
            rdata[THR_HIGH_LSB +: DATA_W] = high;
         end
         ADDR_STATUS: begin
            rdata[ST_BUSY]          = busy;
            rdata[ST_ABOVE]         = above;
            rdata[ST_BELOW]         = below;
            rdata[ST_CNT_LSB +: 16] = smp_cnt;
         end
      endcase
   end

   assign av.readdata  = rdata;
   assign out_of_range = oor;

endmodule

// File: tb/tb_verin_adc_avalon.sv
// Directed bench for verin_adc_avalon with an MCP3201 behavioural model.
module tb_verin_adc_avalon;
   import verin_adc_pkg::*;

   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 200;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic adc_cs_n, adc_sclk, adc_dout, out_of_range;

   int passed = 0;
   int total  = 0;

   logic [11:0] adc_word = '0;
   logic [14:0] frame = '0;
   int bit_idx = 15;
   int rises = 0;
   int falls = 0;
   int cyc = 0;
   int prev_fall = 0;
   int last_fall = 0;
   logic prev_cs = 1'b1;
   logic prev_sclk = 1'b0;

   always #5 clk = ~clk;

   verin_adc_avalon_if av();

   verin_adc_avalon #(
      .CLK_DIV (CLK_DIV),
      .PERIOD  (PERIOD),
      .DATA_W  (12)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .av           (av),
      .adc_cs_n     (adc_cs_n),
      .adc_sclk     (adc_sclk),
      .adc_dout     (adc_dout),
      .out_of_range (out_of_range)
   );

   always @(posedge clk) cyc++;

   // ADC model: frame = 2 sample bits + null + B11..B0, shifted out on sclk falls
   always @(negedge clk) begin
      if (prev_cs && !adc_cs_n) begin
         frame     = {3'b101, adc_word};
         bit_idx   = 0;
         rises     = 0;
         falls++;
         prev_fall = last_fall;
         last_fall = cyc;
      end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
         bit_idx++;
      end
      if (!prev_sclk && adc_sclk) rises++;
      prev_cs   = adc_cs_n;
      prev_sclk = adc_sclk;
   end

   assign adc_dout = (bit_idx < 15) ? frame[14 - bit_idx] : 1'b0;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic bus_idle();
      av.chipselect = 1'b0;
      av.read_n     = 1'b1;
      av.write_n    = 1'b1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      av.address    = a;
      av.writedata  = d;
      av.chipselect = 1'b1;
      av.write_n    = 1'b0;
      tick();
      bus_idle();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      av.address    = a;
      av.chipselect = 1'b1;
      av.read_n     = 1'b0;
      #1 d = av.readdata;
      tick();
      bus_idle();
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      av.address    = a;
      av.chipselect = 1'b0;
      #1 d = av.readdata;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      s = '1;
      for (int n = 0; n < 400; n++) begin
         peek(ADDR_STATUS, s);
         if (!s[ST_BUSY]) break;
         tick();
      end
      chk(tag, {31'b0, s[ST_BUSY]}, 32'h0);
   endtask

   task automatic wait_rises(input string tag, input int target);
      for (int n = 0; n < 300 && rises != target; n++) tick();
      chk(tag, rises, target);
   endtask

   task automatic run_frame(input logic [11:0] w);
      adc_word = w;
      wr(ADDR_CTRL, 32'h2);
      wait_idle("frame_done");
   endtask

   initial begin
      logic [31:0] d;
      int f0;
      bus_idle();
      av.address   = '0;
      av.writedata = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      peek(ADDR_STATUS, d);
      chk("rst_status", d, 32'h0000_0000);
      peek(ADDR_THRESH, d);
      chk("rst_thresh", d, 32'h0FFF_0000);
      peek(ADDR_DATA, d);
      chk("rst_data", d, 32'h0000_0000);
      chk("rst_cs_n", {31'b0, adc_cs_n}, 32'h1);
      chk("rst_sclk", {31'b0, adc_sclk}, 32'h0);
      chk("rst_oor", {31'b0, out_of_range}, 32'h0);

      // single conversion; START during the frame is dropped
      adc_word = 12'hA5C;
      wr(ADDR_CTRL, 32'h2);
      repeat (3) tick();
      wr(ADDR_CTRL, 32'h2);
      wait_idle("first_idle");
      chk("sclk_rises", rises, 15);
      rd(ADDR_DATA, d);
      chk("data_new", d, 32'h8000_0A5C);
      rd(ADDR_DATA, d);
      chk("data_cleared", d, 32'h0000_0A5C);
      peek(ADDR_STATUS, d);
      chk("count_1", d, 32'h0001_0000);
      repeat (100) tick();
      chk("start_busy_ignored", falls, 1);

      // window compare
      wr(ADDR_THRESH, 32'h0800_0100);
      run_frame(12'h900);
      chk("oor_above", {31'b0, out_of_range}, 32'h1);
      peek(ADDR_STATUS, d);
      chk("status_above", d, 32'h0002_0002);
      run_frame(12'h400);
      chk("oor_inside", {31'b0, out_of_range}, 32'h0);
      peek(ADDR_STATUS, d);
      chk("status_inside", d, 32'h0003_0000);
      run_frame(12'h050);
      chk("oor_below", {31'b0, out_of_range}, 32'h1);
      peek(ADDR_STATUS, d);
      chk("status_below", d, 32'h0004_0004);
      wr(ADDR_THRESH, 32'h0FFF_0000);
      tick();
      chk("thresh_no_reeval", {31'b0, out_of_range}, 32'h1);
      peek(ADDR_STATUS, d);
      chk("status_no_reeval", d, 32'h0004_0004);
      run_frame(12'h050);
      chk("oor_new_thresh", {31'b0, out_of_range}, 32'h0);

      // continuous mode, then CONT cleared mid-frame
      adc_word = 12'h123;
      f0 = falls;
      wr(ADDR_CTRL, 32'h1);
      for (int n = 0; n < 1000 && falls != f0 + 3; n++) tick();
      chk("cont_three_starts", falls - f0, 3);
      chk("cont_period", last_fall - prev_fall, PERIOD);
      repeat (10) tick();
      wr(ADDR_CTRL, 32'h0);
      wait_idle("cont_idle");
      peek(ADDR_STATUS, d);
      chk("cont_count", d, 32'h0008_0000);
      peek(ADDR_DATA, d);
      chk("cont_data", d, 32'h8000_0123);
      f0 = falls;
      repeat (400) tick();
      chk("cont_stopped", falls, f0);

      // count wrap and DATA read coincident with the sample update
      force dut.smp_cnt = 16'hFFFF;
      tick();
      release dut.smp_cnt;
      tick();
      peek(ADDR_STATUS, d);
      chk("cnt_preload", d, 32'hFFFF_0000);
      adc_word = 12'h7E1;
      wr(ADDR_CTRL, 32'h2);
      wait_rises("rises_before_hold", 15);
      av.address    = ADDR_DATA;
      av.chipselect = 1'b1;
      av.read_n     = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (adc_cs_n) break;
      end
      d = av.readdata;
      chk("new_coincident", d, 32'h8000_07E1);
      bus_idle();
      wait_idle("wrap_idle");
      peek(ADDR_STATUS, d);
      chk("cnt_wrap", d, 32'h0000_0000);
      peek(ADDR_DATA, d);
      chk("new_kept", d, 32'h8000_07E1);

      // asynchronous reset in the middle of the shift phase
      adc_word = 12'h3C3;
      wr(ADDR_CTRL, 32'h2);
      wait_rises("rises_bit8", 8);
      reset_n = 1'b0;
      #1;
      chk("arst_cs_n", {31'b0, adc_cs_n}, 32'h1);
      chk("arst_sclk", {31'b0, adc_sclk}, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      peek(ADDR_DATA, d);
      chk("arst_data", d, 32'h0000_0000);
      peek(ADDR_STATUS, d);
      chk("arst_status", d, 32'h0000_0000);
      chk("arst_oor", {31'b0, out_of_range}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
